// File: rtl/trng_bias_cal.sv
// Bias calibration for the ring-oscillator TRNG: SAR search of the VDAC code
// toward 50 % ones density, then von Neumann debiasing with drift monitoring.
module trng_bias_cal #(
  parameter int unsigned BITWIDTH      = 8,
  parameter int unsigned WIN_LOG2      = 10,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned TOL           = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_in,
  input  logic                cal_start,
  output logic [BITWIDTH-1:0] vdac_code,
  output logic                busy,
  output logic                locked,
  output logic                rnd_bit,
  output logic                rnd_valid,
  output logic [WIN_LOG2:0]   ones_count,
  output logic                drift_err
);

  localparam int unsigned CNT_W = WIN_LOG2 + 1;
  localparam int unsigned IDX_W = (BITWIDTH > 1) ? $clog2(BITWIDTH) : 1;
  localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [CNT_W-1:0]    HALF        = CNT_W'(2 ** (WIN_LOG2 - 1));
  localparam logic [SET_W-1:0]    SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0]    TOP_IDX     = IDX_W'(BITWIDTH - 1);
  localparam logic [BITWIDTH-1:0] MID_CODE    = {1'b1, {(BITWIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    MEASURE,
    ADJUST,
    LOCKED
  } state_t;

  state_t              state_q, state_d;
  logic [BITWIDTH-1:0] vdac_q, vdac_d;
  logic [IDX_W-1:0]    bit_idx_q, bit_idx_d;
  logic [SET_W-1:0]    settle_cnt_q, settle_cnt_d;
  logic [WIN_LOG2-1:0] win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0]    ones_q, ones_d;
  logic [CNT_W-1:0]    ones_count_q, ones_count_d;
  logic                busy_q, busy_d;
  logic                locked_q, locked_d;
  logic                rnd_bit_q, rnd_bit_d;
  logic                rnd_valid_q, rnd_valid_d;
  logic                drift_q, drift_d;
  logic                pair_full_q, pair_full_d;
  logic                pair_a_q, pair_a_d;

  logic [CNT_W-1:0]    win_total;
  logic [CNT_W-1:0]    win_dev;
  logic [IDX_W-1:0]    idx_m1;
  logic                start;

  always_comb begin
    state_d      = state_q;
    vdac_d       = vdac_q;
    bit_idx_d    = bit_idx_q;
    settle_cnt_d = settle_cnt_q;
    win_cnt_d    = win_cnt_q;
    ones_d       = ones_q;
    ones_count_d = ones_count_q;
    busy_d       = busy_q;
    locked_d     = locked_q;
    rnd_bit_d    = rnd_bit_q;
    rnd_valid_d  = 1'b0;
    drift_d      = drift_q;
    pair_full_d  = pair_full_q;
    pair_a_d     = pair_a_q;

    win_total = ones_q + CNT_W'(sample_in);
    win_dev   = (win_total >= HALF) ? (win_total - HALF) : (HALF - win_total);
    idx_m1    = bit_idx_q - 1'b1;
    start     = cal_start && ((state_q == IDLE) || (state_q == LOCKED));

    case (state_q)
      IDLE: ;

      SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) begin
          ones_d    = '0;
          win_cnt_d = '0;
          state_d   = MEASURE;
        end else begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end

      MEASURE: begin
        ones_d    = win_total;
        win_cnt_d = win_cnt_q + 1'b1;
        if (win_cnt_q == '1) begin
          state_d = ADJUST;
        end
      end

      ADJUST: begin
        ones_count_d = ones_q;
        // Density at or above half means the trial code is too high.
        if (ones_q >= HALF) begin
          vdac_d[bit_idx_q] = 1'b0;
        end
        if (bit_idx_q != '0) begin
          bit_idx_d      = idx_m1;
          vdac_d[idx_m1] = 1'b1;
          settle_cnt_d   = '0;
          state_d        = SETTLE;
        end else begin
          busy_d      = 1'b0;
          locked_d    = 1'b1;
          ones_d      = '0;
          win_cnt_d   = '0;
          pair_full_d = 1'b0;
          state_d     = LOCKED;
        end
      end

      LOCKED: begin
        if (pair_full_q) begin
          pair_full_d = 1'b0;
          if (pair_a_q != sample_in) begin
            rnd_bit_d   = pair_a_q;
            rnd_valid_d = 1'b1;
          end
        end else begin
          pair_full_d = 1'b1;
          pair_a_d    = sample_in;
        end

        win_cnt_d = win_cnt_q + 1'b1;
        if (win_cnt_q == '1) begin
          ones_count_d = win_total;
          ones_d       = '0;
          if (32'(win_dev) > TOL) begin
            drift_d = 1'b1;
          end
        end else begin
          ones_d = win_total;
        end
      end

      default: state_d = IDLE;
    endcase

    // A restart pre-empts whatever LOCKED computed this cycle, including a pair result.
    if (start) begin
      vdac_d       = MID_CODE;
      bit_idx_d    = TOP_IDX;
      settle_cnt_d = '0;
      locked_d     = 1'b0;
      drift_d      = 1'b0;
      pair_full_d  = 1'b0;
      rnd_valid_d  = 1'b0;
      busy_d       = 1'b1;
      state_d      = SETTLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      vdac_q       <= '0;
      bit_idx_q    <= '0;
      settle_cnt_q <= '0;
      win_cnt_q    <= '0;
      ones_q       <= '0;
      ones_count_q <= '0;
      busy_q       <= 1'b0;
      locked_q     <= 1'b0;
      rnd_bit_q    <= 1'b0;
      rnd_valid_q  <= 1'b0;
      drift_q      <= 1'b0;
      pair_full_q  <= 1'b0;
      pair_a_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      vdac_q       <= vdac_d;
      bit_idx_q    <= bit_idx_d;
      settle_cnt_q <= settle_cnt_d;
      win_cnt_q    <= win_cnt_d;
      ones_q       <= ones_d;
      ones_count_q <= ones_count_d;
      busy_q       <= busy_d;
      locked_q     <= locked_d;
      rnd_bit_q    <= rnd_bit_d;
      rnd_valid_q  <= rnd_valid_d;
      drift_q      <= drift_d;
      pair_full_q  <= pair_full_d;
      pair_a_q     <= pair_a_d;
    end
  end

  assign vdac_code  = vdac_q;
  assign busy       = busy_q;
  assign locked     = locked_q;
  assign rnd_bit    = rnd_bit_q;
  assign rnd_valid  = rnd_valid_q;
  assign ones_count = ones_count_q;
  assign drift_err  = drift_q;

endmodule

// File: tb/tb_trng_bias_cal.sv
// Scoreboard bench for trng_bias_cal: stimulus pushes expected trial codes, lock
// results and random bits; a negedge monitor pops them as the DUT presents them.
module tb_trng_bias_cal;

  logic       clk;
  logic       rst;
  logic       sample_in;
  logic       cal_start;
  logic [7:0] vdac_code;
  logic       busy;
  logic       locked;
  logic       rnd_bit;
  logic       rnd_valid;
  logic [4:0] ones_count;
  logic       drift_err;

  logic thr_mode;
  logic drv;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] code;
    logic [4:0] ones;
  } lock_t;

  logic [7:0] exp_trial [$];
  lock_t      exp_lock  [$];
  logic       exp_rnd   [$];

  logic [7:0] tr_thr  [8] = '{8'h80, 8'h40, 8'h60, 8'h50, 8'h58, 8'h5C, 8'h5A, 8'h5B};
  logic [7:0] tr_zero [8] = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};
  logic [7:0] tr_one  [8] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
  logic       stream  [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

  logic [7:0] prev_vdac   = '0;
  logic       prev_locked = 1'b0;

  // Threshold oscillator model: ones density jumps to 100 % at code 0x5B.
  assign sample_in = thr_mode ? (vdac_code >= 8'h5B) : drv;

  trng_bias_cal #(
    .BITWIDTH     (8),
    .WIN_LOG2     (4),
    .SETTLE_CYCLES(2),
    .TOL          (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sample_in (sample_in),
    .cal_start (cal_start),
    .vdac_code (vdac_code),
    .busy      (busy),
    .locked    (locked),
    .rnd_bit   (rnd_bit),
    .rnd_valid (rnd_valid),
    .ones_count(ones_count),
    .drift_err (drift_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic miss(input string name);
    checks++;
    errors++;
    $display("FAIL %s: DUT output with no expected entry at %0t", name, $time);
  endtask

  always @(negedge clk) begin
    if (busy && (vdac_code != prev_vdac)) begin
      if (exp_trial.size() == 0) miss("trial_code");
      else chk("trial_code", 32'(vdac_code), 32'(exp_trial.pop_front()));
    end
    if (locked && !prev_locked) begin
      if (exp_lock.size() == 0) begin
        miss("lock_result");
      end else begin
        lock_t e;
        e = exp_lock.pop_front();
        chk("lock_code", 32'(vdac_code), 32'(e.code));
        chk("lock_ones", 32'(ones_count), 32'(e.ones));
      end
    end
    if (rnd_valid) begin
      chk("rnd_only_locked", 32'(locked), 32'd1);
      if (exp_rnd.size() == 0) miss("rnd_bit");
      else chk("rnd_bit", 32'(rnd_bit), 32'(exp_rnd.pop_front()));
    end
    prev_vdac   <= vdac_code;
    prev_locked <= locked;
  end

  // Pulses cal_start (cycle 0) and returns at the negedge of cycle 153.
  task automatic run_cal(input int ign);
    @(negedge clk) cal_start = 1'b1;
    @(negedge clk) cal_start = 1'b0;
    chk("busy_c1", 32'(busy), 32'd1);
    chk("locked_c1", 32'(locked), 32'd0);
    chk("drift_c1", 32'(drift_err), 32'd0);
    for (int c = 2; c <= 153; c++) begin
      @(negedge clk);
      cal_start = (c == ign);
      if (c == 152) begin
        chk("busy_c152", 32'(busy), 32'd1);
        chk("locked_c152", 32'(locked), 32'd0);
      end
      if (c == 153) begin
        chk("busy_c153", 32'(busy), 32'd0);
        chk("locked_c153", 32'(locked), 32'd1);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    cal_start = 1'b0;
    thr_mode  = 1'b0;
    drv       = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_vdac", 32'(vdac_code), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_rnd_valid", 32'(rnd_valid), 32'd0);
    chk("rst_ones", 32'(ones_count), 32'd0);
    chk("rst_drift", 32'(drift_err), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Threshold search
    thr_mode = 1'b1;
    for (int i = 0; i < 8; i++) exp_trial.push_back(tr_thr[i]);
    exp_lock.push_back('{code: 8'h5A, ones: 5'd16});
    run_cal(0);

    // Debias stream, first pair starts on the first LOCKED cycle
    thr_mode = 1'b0;
    exp_rnd.push_back(1'b1);
    exp_rnd.push_back(1'b0);
    drv = stream[0];
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      drv = stream[i];
    end

    // Drift: all-ones windows while locked
    @(negedge clk) drv = 1'b1;
    repeat (40) @(negedge clk);
    chk("drift_ones", 32'(ones_count), 32'd16);
    chk("drift_flag", 32'(drift_err), 32'd1);
    chk("drift_vdac", 32'(vdac_code), 32'h5A);
    chk("drift_locked", 32'(locked), 32'd1);
    chk("rnd_drained", 32'(exp_rnd.size()), 32'd0);

    // Tied low, restart from LOCKED
    drv = 1'b0;
    for (int i = 0; i < 8; i++) exp_trial.push_back(tr_zero[i]);
    exp_lock.push_back('{code: 8'hFF, ones: 5'd0});
    run_cal(0);

    // Tied high, with an ignored cal_start mid-search
    drv = 1'b1;
    for (int i = 0; i < 8; i++) exp_trial.push_back(tr_one[i]);
    exp_lock.push_back('{code: 8'h00, ones: 5'd16});
    run_cal(70);

    // Reset at cycle 60 of a threshold calibration
    thr_mode = 1'b1;
    for (int i = 0; i < 4; i++) exp_trial.push_back(tr_thr[i]);
    @(negedge clk) cal_start = 1'b1;
    @(negedge clk) cal_start = 1'b0;
    for (int c = 2; c <= 60; c++) begin
      @(negedge clk);
      cal_start = (c == 30);
      if (c == 60) rst = 1'b1;
    end
    @(negedge clk) rst = 1'b0;
    chk("abort_vdac", 32'(vdac_code), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_locked", 32'(locked), 32'd0);
    chk("abort_rnd_valid", 32'(rnd_valid), 32'd0);
    chk("abort_ones", 32'(ones_count), 32'd0);
    chk("abort_drift", 32'(drift_err), 32'd0);
    chk("abort_trials", 32'(exp_trial.size()), 32'd0);
    repeat (3) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    // cal_start coincident with rst
    rst       = 1'b1;
    cal_start = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    cal_start = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_win_busy", 32'(busy), 32'd0);
    chk("rst_win_vdac", 32'(vdac_code), 32'd0);
    chk("rst_win_locked", 32'(locked), 32'd0);

    chk("trial_q_empty", 32'(exp_trial.size()), 32'd0);
    chk("lock_q_empty", 32'(exp_lock.size()), 32'd0);
    chk("rnd_q_empty", 32'(exp_rnd.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
